// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared sequencer state encoding and default address constants
package mips_cpu_pkg;
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, STALL = 2'd2, HALTED = 2'd3} state_t;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;
    function automatic int timer_width(input int limit);
        return limit < 1 ? 1 : $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/mips_cpu_sequencer_wait_timer.sv
// wait_timer: saturating wait-cycle counter; expired flags the LIMIT-th consecutive wait
module wait_timer
    import mips_cpu_pkg::*;
#(
    parameter int LIMIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = timer_width(LIMIT);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable && count != '1) count <= count + 1'b1;
    end
    // expired fires on the wait cycle that brings the count up to LIMIT
    assign expired = (LIMIT != 0) && enable && (int'(count) + 1 >= LIMIT);
endmodule

// File: rtl/mips_cpu_sequencer.sv
// mips_cpu_sequencer: PC, fetch/execute FSM, delay-slot redirect, halt and wait-state handling
module mips_cpu_sequencer
    import mips_cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(DEFAULT_HALT_ADDR),
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    output logic [ADDR_W-1:0] instr_address,
    output logic              instr_read,
    input  logic              instr_waitrequest,
    input  logic              data_access,
    input  logic              data_waitrequest,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              commit,
    output logic              active,
    output logic              bus_error,
    output logic [1:0]        state
);
    state_t            st, st_n;
    logic [ADDR_W-1:0] pc, pc_n, pending_target, tgt_n, next_pc;
    logic              pending, pend_n, active_n, err_n, retire, waiting, expired;
    assign pc_plus4 = pc + ADDR_W'(4);
    // the delay-slot instruction jumps to the stored target, everything else falls through
    assign next_pc = pending ? pending_target : pc_plus4;
    assign waiting = (st == FETCH && instr_waitrequest) || (st == STALL && data_waitrequest);
    assign instr_address = pc;
    assign state = st;
    assign instr_read = reset && st == FETCH;
    assign commit = reset && clk_enable && retire;
    wait_timer #(.LIMIT(WAIT_TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(clk_enable && !waiting),
        .enable(clk_enable && waiting),
        .expired(expired)
    );
    always_comb begin
        st_n = st;
        pc_n = pc;
        pend_n = pending;
        tgt_n = pending_target;
        active_n = active;
        err_n = bus_error;
        retire = 1'b0;
        case (st)
            FETCH: begin
                if (expired) begin
                    st_n = HALTED;
                    active_n = 1'b0;
                    err_n = 1'b1;
                end else if (!instr_waitrequest) begin
                    st_n = EXEC;
                end
            end
            EXEC, STALL: begin
                if (expired) begin
                    st_n = HALTED;
                    active_n = 1'b0;
                    err_n = 1'b1;
                end else if (data_access && data_waitrequest) begin
                    st_n = STALL;
                end else begin
                    retire = 1'b1;
                    pc_n = next_pc;
                    pend_n = !pending && redirect;
                    tgt_n = (!pending && redirect) ? redirect_target : pending_target;
                    active_n = next_pc != HALT_ADDR;
                    st_n = next_pc == HALT_ADDR ? HALTED : FETCH;
                end
            end
            HALTED: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            st <= FETCH;
            pc <= RESET_VECTOR;
            pending <= 1'b0;
            pending_target <= '0;
            active <= 1'b1;
            bus_error <= 1'b0;
        end else if (clk_enable) begin
            st <= st_n;
            pc <= pc_n;
            pending <= pend_n;
            pending_target <= tgt_n;
            active <= active_n;
            bus_error <= err_n;
        end
    end
endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// tb_mips_cpu_sequencer: directed vectors, corner sequences and random run against an instruction-level model
module tb_mips_cpu_sequencer;
    logic        clk = 1'b0, reset = 1'b0, clk_enable = 1'b1;
    logic        instr_waitrequest = 1'b0, data_access = 1'b0, data_waitrequest = 1'b0, redirect = 1'b0;
    logic [31:0] redirect_target = '0, instr_address, pc_plus4;
    logic        instr_read, commit, active, bus_error;
    logic [1:0]  state;
    int          ncmp = 0, nfail = 0;
    always #5 clk = ~clk;
    mips_cpu_sequencer #(.ADDR_W(32), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .instr_address(instr_address), .instr_read(instr_read), .instr_waitrequest(instr_waitrequest),
        .data_access(data_access), .data_waitrequest(data_waitrequest),
        .redirect(redirect), .redirect_target(redirect_target),
        .pc_plus4(pc_plus4), .commit(commit), .active(active), .bus_error(bus_error), .state(state)
    );
    // instruction-level model: pending branch targets kept as a queue of future PCs
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_fetched, m_stalled, m_halted, m_err, mv = 0;
    int          m_streak;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic model_step();
        logic [31:0] npc;
        if (!reset) begin
            m_pc = 32'hBFC0_0000;
            m_q.delete();
            {m_fetched, m_stalled, m_halted, m_err} = '0;
            m_streak = 0;
            mv = 1;
        end else if (clk_enable && !m_halted && mv) begin
            if (!m_fetched) begin
                if (instr_waitrequest) begin
                    m_streak++;
                    if (m_streak >= 4) {m_halted, m_err} = 2'b11;
                end else begin
                    m_fetched = 1;
                    m_streak = 0;
                end
            end else if (data_access && data_waitrequest) begin
                if (m_stalled) begin
                    m_streak++;
                    if (m_streak >= 4) {m_halted, m_err} = 2'b11;
                end
                m_stalled = 1;
            end else begin
                if (m_q.size() > 0) npc = m_q.pop_front();
                else begin
                    npc = m_pc + 32'd4;
                    if (redirect) m_q.push_back(redirect_target);
                end
                m_pc = npc;
                {m_fetched, m_stalled} = '0;
                m_streak = 0;
                if (npc == 32'h0) m_halted = 1;
            end
        end
    endtask
    task automatic apply(input logic r, e, iw, da, dw, rd, input logic [31:0] tg);
        @(negedge clk);
        reset = r;
        clk_enable = e;
        instr_waitrequest = iw;
        data_access = da;
        data_waitrequest = dw;
        redirect = rd;
        redirect_target = tg;
        #1;
    endtask
    task automatic tick();
        if (mv) begin
            chk("state", 32'(state), m_halted ? 3 : !m_fetched ? 0 : m_stalled ? 2 : 1);
            chk("instr_address", instr_address, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("commit", 32'(commit), 32'(reset && clk_enable && !m_halted && m_fetched && !(data_access && data_waitrequest)));
            chk("instr_read", 32'(instr_read), 32'(reset && !m_halted && !m_fetched));
            chk("active", 32'(active), 32'(!m_halted));
            chk("bus_error", 32'(bus_error), 32'(m_err));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask
    typedef struct {
        logic        iw, da, dw, rd;
        logic [31:0] tg;
        logic [1:0]  xs;
        logic        xc;
        logic [31:0] xa;
    } vec_t;
    vec_t tbl[13];
    logic        s_da, s_rd;
    logic [31:0] s_tg;
    int          hc;
    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 2'd1, 1'b1, 32'hBFC0_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0004};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0200, 2'd1, 1'b1, 32'hBFC0_0004};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd1, 1'b1, 32'hBFC0_0100};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0104};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0104};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'd1, 1'b0, 32'hBFC0_0104};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'd2, 1'b0, 32'hBFC0_0104};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         2'd2, 1'b0, 32'hBFC0_0104};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'd2, 1'b1, 32'hBFC0_0104};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 32'hBFC0_0108};
        apply(0, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 13; i++) begin
            apply(1, 1, tbl[i].iw, tbl[i].da, tbl[i].dw, tbl[i].rd, tbl[i].tg);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].xs));
            chk($sformatf("vec%0d_commit", i), 32'(commit), 32'(tbl[i].xc));
            chk($sformatf("vec%0d_addr", i), instr_address, tbl[i].xa);
            tick();
        end
        // jr to 0 from 0xBFC00010: delay slot retires, then the core halts
        apply(0, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
        end
        apply(1, 1, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 0, 0, 0, 1, 32'h0);
        chk("jr_addr", instr_address, 32'hBFC0_0010);
        chk("jr_commit", 32'(commit), 1);
        tick();
        apply(1, 1, 0, 0, 0, 0, 0);
        chk("slot_addr", instr_address, 32'hBFC0_0014);
        tick();
        chk("slot_commit", 32'(commit), 1);
        tick();
        chk("halt_state", 32'(state), 3);
        chk("halt_active", 32'(active), 0);
        chk("halt_pc", instr_address, 32'h0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 0, 0, 0, 1, 32'h40);
            chk("halt_commit", 32'(commit), 0);
            chk("halt_iread", 32'(instr_read), 0);
            tick();
        end
        // instruction fetch stuck in wait: bus_error on the fourth wait cycle
        apply(0, 1, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("to_err_early", 32'(bus_error), 0);
        chk("to_state_early", 32'(state), 0);
        tick();
        chk("to_err", 32'(bus_error), 1);
        chk("to_active", 32'(active), 0);
        chk("to_state", 32'(state), 3);
        apply(0, 1, 1, 0, 0, 0, 0);
        tick();
        chk("to_clr_err", 32'(bus_error), 0);
        chk("to_clr_active", 32'(active), 1);
        chk("to_clr_state", 32'(state), 0);
        // clk_enable low mid-stall, then reset while still disabled
        apply(1, 1, 0, 1, 1, 0, 0);
        tick();
        tick();
        tick();
        chk("frz_pre_state", 32'(state), 2);
        for (int i = 0; i < 5; i++) begin
            apply(1, 0, 0, 1, i[0], 0, 0);
            chk("frz_commit", 32'(commit), 0);
            tick();
            chk("frz_state", 32'(state), 2);
            chk("frz_addr", instr_address, 32'hBFC0_0000);
        end
        apply(0, 0, 0, 1, 1, 0, 0);
        tick();
        chk("frz_rst_state", 32'(state), 0);
        chk("frz_rst_addr", instr_address, 32'hBFC0_0000);
        // random run against the model; datapath inputs held while stalled
        hc = 0;
        s_da = 0;
        s_rd = 0;
        s_tg = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!m_stalled) begin
                s_da = $urandom_range(0, 1) == 1;
                s_rd = $urandom_range(0, 3) == 0;
                s_tg = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom_range(0, 7) == 0 ? 32'hFFFF_FFFC : $urandom;
            end else s_da = 1;
            apply(!($urandom_range(0, 99) < 2 || hc > 6), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 2) == 0, s_da, $urandom_range(0, 2) == 0, s_rd, s_tg);
            tick();
            hc = m_halted ? hc + 1 : 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/mips_cpu_sequencer.md
# mips_cpu_sequencer

Parametrised control sequencer for the Harvard MIPS core: owns the PC, the fetch/execute state machine, branch-delay-slot redirection, halt detection and stall handling for instruction/data memories that may insert wait states. Sits between the control/branch logic (which supplies redirect requests and targets) and the memory ports, and produces the `commit` strobe that gates every architectural write (register file, HI/LO, data_write).

## Interface
- `ADDR_W`, 32: PC/address width.
- `RESET_VECTOR`, `'hBFC00000`: PC loaded on reset.
- `HALT_ADDR`, 0: committing a next-PC equal to this halts the core.
- `WAIT_TIMEOUT`, 0: max consecutive wait cycles before `bus_error`; 0 disables the timer.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `clk_enable`  in  1  0 freezes all state; `commit` forced 0.
- `instr_address`  out  ADDR_W  current PC.
- `instr_read`  out  1  fetch request, high in FETCH only.
- `instr_waitrequest`  in  1  1 = instruction not yet valid.
- `data_access`  in  1  current instruction uses data memory (load/store).
- `data_waitrequest`  in  1  1 = data access not complete.
- `redirect`  in  1  current instruction is a taken branch or jump (j/jal/jr/jalr/bxx).
- `redirect_target`  in  ADDR_W  target of that redirect.
- `pc_plus4`  out  ADDR_W  PC+4, modulo 2^ADDR_W (link value).
- `commit`  out  1  current instruction retires this cycle.
- `active`  out  1  core running.
- `bus_error`  out  1  sticky wait-timeout flag.
- `state`  out  2  FETCH=0, EXEC=1, STALL=2, HALTED=3.

## Operation
- Reset (`reset`=0 at edge): PC=RESET_VECTOR, state=FETCH, active=1, pending=0, bus_error=0, wait counter=0. Combinationally while reset=0: commit=0, instr_read=0. Reset wins over clk_enable and every other input, including mid-stall.
- FETCH: instr_read=1. instr_waitrequest=0 → EXEC; else stay and count.
- EXEC: if data_access && data_waitrequest → STALL, commit=0. Otherwise commit=1 and retire:
  - pending=1 (this is the delay slot): next PC = pending_target, pending←0; `redirect` ignored.
  - pending=0, redirect=1: next PC = PC+4, pending←1, pending_target←redirect_target.
  - otherwise: next PC = PC+4.
  - next PC == HALT_ADDR (full ADDR_W compare) → HALTED, active←0, PC←HALT_ADDR; else → FETCH.
- STALL: commit=1 and retire exactly as EXEC on the first cycle data_waitrequest=0; else stay and count. Inputs must be held stable by the datapath while in STALL.
- Wait counter: increments each cycle in FETCH with instr_waitrequest=1 or STALL with data_waitrequest=1, clears on leaving that state. When WAIT_TIMEOUT≠0 and counter reaches WAIT_TIMEOUT: bus_error←1, active←0, state←HALTED, no commit. Counter saturates, width $clog2(WAIT_TIMEOUT+1) (min 1).
- HALTED: absorbing; only reset leaves. commit=0, instr_read=0.
- clk_enable=0: no state, PC, pending or counter update; commit=0; instr_read still reflects state.

## Timing
- Zero-wait instruction: 2 cycles (FETCH, EXEC); commit one cycle, in EXEC.
- Each wait cycle adds exactly one cycle; commit is always a single-cycle pulse per instruction.
- commit, instr_read are combinational from state/inputs; everything else registered.
- Redirect takes effect after exactly one delay-slot instruction; instr_address changes the cycle after commit.
- PC+4 from 0xFFFFFFFC wraps to 0 and halts (HALT_ADDR=0).

## Structure
- `mips_cpu_pkg`: `state_t` enum (FETCH/EXEC/STALL/HALTED), default RESET_VECTOR and HALT_ADDR constants; shared with the CPU top.
- One sub-module: `wait_timer` (parametrised saturating counter with clear, enable, `expired` output); PC+4 adder inline.

## Test plan
- Reset then zero waits, no redirects: instr_address 0xBFC00000, 0xBFC00004, 0xBFC00008 at 2-cycle spacing; one commit pulse each.
- Redirect at 0xBFC00000 to 0xBFC00100: next fetch 0xBFC00004 (delay slot), then 0xBFC00100; redirect asserted in delay slot is ignored.
- jr to 0 at 0xBFC00010: delay slot 0xBFC00014 commits, then state=HALTED, active=0, PC=0, no further commits.
- data_access with data_waitrequest high 3 cycles: state EXEC→STALL×3, single commit on 4th cycle, instruction takes 5 cycles.
- WAIT_TIMEOUT=4, instr_waitrequest stuck high: bus_error=1, active=0, state=HALTED after 4 wait cycles; reset=0 clears all.
- clk_enable low 5 cycles mid-STALL, then reset=0 asserted while clk_enable=0: frozen during enable low, then PC=0xBFC00000, state=FETCH.
